i2s_tx_scheduler: RTL and testbench

- Shares one I2S transmitter between NREQ audio sources and sequences its frame loading.
- Arbitrates round-robin among requesting sources and captures the winner's stereo frame into a one-entry hold register.
- Presents the held frame on LoadData at each transmitter frame-boundary pulse.
- Substitutes silence (all zeros) and flags an underrun when no frame is held at a boundary.

---
 rtl/i2s_tx_scheduler_if.sv | 43 ++++
 rtl/i2s_tx_scheduler.sv | 135 +++++++++++++
 tb/tb_i2s_tx_scheduler.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tx_scheduler_if
// Description : Source-request and transmitter-load bundle for i2s_tx_scheduler.
//               Optional macro: I2S_TX_SCHEDULER_UNDERRUN_CNT_EN adds underrun_count.
// Revision    : 1.0 - initial release
// ============================================================================
interface i2s_tx_scheduler_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2
);
    localparam int c_SRCW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]         req;
    logic [NREQ*2*WIDTH-1:0] req_data;
    logic [NREQ-1:0]         gnt;
    logic                    tx_ready;
    logic [2*WIDTH-1:0]      LoadData;
    logic                    underrun;
    logic [c_SRCW-1:0]       active_src;
`ifdef I2S_TX_SCHEDULER_UNDERRUN_CNT_EN
    logic [15:0]             underrun_count;

    modport master (
        input  req, req_data, tx_ready,
        output gnt, LoadData, underrun, active_src, underrun_count
    );
    modport slave (
        output req, req_data, tx_ready,
        input  gnt, LoadData, underrun, active_src, underrun_count
    );
`else
    modport master (
        input  req, req_data, tx_ready,
        output gnt, LoadData, underrun, active_src
    );
    modport slave (
        output req, req_data, tx_ready,
        input  gnt, LoadData, underrun, active_src
    );
`endif
endinterface
`default_nettype wire

// File: rtl/i2s_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tx_scheduler
// Description : Round-robin frame scheduler feeding one I2S transmitter.
//               Optional macro: I2S_TX_SCHEDULER_UNDERRUN_CNT_EN (underrun counter).
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx_scheduler #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2
) (
    input  wire logic          SCK,
    input  wire logic          nreset,
    input  wire logic          enable,
    i2s_tx_scheduler_if.master bus
);
    localparam int                c_FW       = 2 * WIDTH;
    localparam int                c_SRCW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [c_SRCW-1:0] c_LAST_RST = c_SRCW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_SRCW-1:0] r_last;
    logic [c_SRCW-1:0] r_hold_src;
    logic [c_FW-1:0]   r_hold;

    logic              w_any;
    logic [c_SRCW-1:0] w_win;
    logic [NREQ-1:0]   w_gnt;
    logic [c_FW-1:0]   w_data;
    logic              w_urun;
    int                w_idx;

    // Search starts just after the last winner and wraps, giving round-robin fairness.
    always_comb begin
        w_any  = 1'b0;
        w_win  = '0;
        w_gnt  = '0;
        w_data = '0;
        w_idx  = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = (int'(r_last) + 1 + i) % NREQ;
            if (!w_any && bus.req[w_idx]) begin
                w_any         = 1'b1;
                w_win         = c_SRCW'(w_idx);
                w_gnt[w_idx]  = 1'b1;
                w_data        = bus.req_data[w_idx*c_FW +: c_FW];
            end
        end
    end

    assign w_urun = (r_state == S_FETCH) && bus.tx_ready;

    always_ff @(posedge SCK) begin
        if (nreset) begin
            r_state        <= S_IDLE;
            r_last         <= c_LAST_RST;
            r_hold         <= '0;
            r_hold_src     <= '0;
            bus.gnt        <= '0;
            bus.LoadData   <= '0;
            bus.underrun   <= 1'b0;
            bus.active_src <= '0;
        end else begin
            bus.gnt      <= '0;
            bus.underrun <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.tx_ready) begin
                        bus.LoadData <= '0;
                    end
                    if (enable) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // A boundary with nothing held is silence, even if a frame lands this cycle.
                    if (w_urun) begin
                        bus.LoadData <= '0;
                        bus.underrun <= 1'b1;
                    end
                    if (w_any) begin
                        r_hold     <= w_data;
                        r_hold_src <= w_win;
                        r_last     <= w_win;
                        bus.gnt    <= w_gnt;
                        r_state    <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (bus.tx_ready) begin
                        bus.LoadData   <= r_hold;
                        bus.active_src <= r_hold_src;
                        r_state        <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            // Leaving the run state drops any held frame; the state alone marks hold validity.
            if (!enable) begin
                r_state <= S_IDLE;
            end
        end
    end

`ifdef I2S_TX_SCHEDULER_UNDERRUN_CNT_EN
    logic        r_enable_d;
    logic [15:0] r_ucnt;

    always_ff @(posedge SCK) begin
        if (nreset) begin
            r_enable_d <= 1'b0;
            r_ucnt     <= '0;
        end else begin
            r_enable_d <= enable;
            if (enable && !r_enable_d) begin
                r_ucnt <= '0;
            end else if (w_urun && (r_ucnt != 16'hFFFF)) begin
                r_ucnt <= r_ucnt + 16'd1;
            end
        end
    end

    assign bus.underrun_count = r_ucnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_tx_scheduler
// Description : Scoreboard bench for i2s_tx_scheduler (WIDTH=8, NREQ=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tx_scheduler;
    localparam int WIDTH = 8;
    localparam int NREQ  = 2;

    typedef struct {
        logic [15:0] data;
        logic        urun;
        int          src;
    } frame_t;

    logic SCK = 1'b0;
    logic nreset;
    logic enable;

    int tests_run    = 0;
    int tests_failed = 0;

    frame_t exp_q[$];
    int     gnt_q[$];

    i2s_tx_scheduler_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    i2s_tx_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .SCK    (SCK),
        .nreset (nreset),
        .enable (enable),
        .bus    (bus)
    );

    always #5 SCK = ~SCK;

    task automatic step();
        @(posedge SCK);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        nreset = 1'b1;
        step();
        step();
        nreset = 1'b0;
    endtask

    task automatic pulse_ready();
        bus.tx_ready = 1'b1;
        step();
        bus.tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.req      = '0;
        bus.req_data = '0;
        bus.tx_ready = 1'b0;
        enable       = 1'b0;
        nreset       = 1'b1;
        step();
        step();
        tests_run++;
        if (bus.gnt !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_gnt: got %b expected 00", bus.gnt);
        end
        tests_run++;
        if (bus.LoadData !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_loaddata: got %h expected 0000", bus.LoadData);
        end
        tests_run++;
        if (bus.underrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_underrun: got %b expected 0", bus.underrun);
        end
        tests_run++;
        if (bus.active_src !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_active_src: got %b expected 0", bus.active_src);
        end
`ifdef I2S_TX_SCHEDULER_UNDERRUN_CNT_EN
        tests_run++;
        if (bus.underrun_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_count: got %0d expected 0", bus.underrun_count);
        end
`endif
        nreset = 1'b0;
    endtask

    task automatic test_single();
        frame_t f;
        int     g;
        bus.req_data[15:0] = 16'h8988;
        bus.req            = 2'b01;
        enable             = 1'b1;
        gnt_q.push_back(0);
        exp_q.push_back('{16'h8988, 1'b0, 0});
        step();
        tests_run++;
        if (bus.gnt !== 2'b00) begin
            tests_failed++;
            $display("FAIL single_gnt_early: got %b expected 00", bus.gnt);
        end
        step();
        g = gnt_q.pop_front();
        tests_run++;
        if (bus.gnt !== 2'(1 << g)) begin
            tests_failed++;
            $display("FAIL single_gnt: got %b expected %b", bus.gnt, 2'(1 << g));
        end
        bus.req = 2'b00;
        step();
        tests_run++;
        if (bus.gnt !== 2'b00) begin
            tests_failed++;
            $display("FAIL single_gnt_width: got %b expected 00", bus.gnt);
        end
        wait_cycles(12);
        tests_run++;
        if (bus.LoadData !== 16'h0000) begin
            tests_failed++;
            $display("FAIL single_load_stable: got %h expected 0000", bus.LoadData);
        end
        pulse_ready();
        f = exp_q.pop_front();
        tests_run++;
        if (bus.LoadData !== f.data || bus.underrun !== f.urun || bus.active_src !== 1'(f.src)) begin
            tests_failed++;
            $display("FAIL single_load: got data=%h urun=%b src=%0d expected data=%h urun=%b src=%0d",
                     bus.LoadData, bus.underrun, bus.active_src, f.data, f.urun, f.src);
        end
    endtask

    task automatic test_alternate();
        frame_t f;
        int     g;
        do_reset();
        bus.req_data = {16'h5555, 16'hAAAA};
        bus.req      = 2'b11;
        gnt_q.push_back(0);
        gnt_q.push_back(1);
        gnt_q.push_back(0);
        gnt_q.push_back(1);
        exp_q.push_back('{16'hAAAA, 1'b0, 0});
        exp_q.push_back('{16'h5555, 1'b0, 1});
        exp_q.push_back('{16'hAAAA, 1'b0, 0});
        for (int cyc = 0; cyc < 16 * 3 + 4; cyc++) begin
            bus.tx_ready = ((cyc % 16) == 15);
            step();
            if (bus.gnt !== 2'b00) begin
                tests_run++;
                if (gnt_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL alt_gnt_extra: got %b expected 00", bus.gnt);
                end else begin
                    g = gnt_q.pop_front();
                    if (bus.gnt !== 2'(1 << g)) begin
                        tests_failed++;
                        $display("FAIL alt_gnt: got %b expected %b", bus.gnt, 2'(1 << g));
                    end
                end
            end
            if (bus.tx_ready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL alt_load_extra: got data=%h expected no boundary", bus.LoadData);
                end else begin
                    f = exp_q.pop_front();
                    if (bus.LoadData !== f.data || bus.underrun !== f.urun || bus.active_src !== 1'(f.src)) begin
                        tests_failed++;
                        $display("FAIL alt_load: got data=%h urun=%b src=%0d expected data=%h urun=%b src=%0d",
                                 bus.LoadData, bus.underrun, bus.active_src, f.data, f.urun, f.src);
                    end
                end
            end
            for (int s = 0; s < NREQ; s++) bus.req[s] = ~bus.gnt[s];
        end
        bus.tx_ready = 1'b0;
        tests_run++;
        if (gnt_q.size() != 0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL alt_missing: got %0d grants/%0d frames left expected 0/0", gnt_q.size(), exp_q.size());
        end
    endtask

    task automatic test_underrun();
        frame_t f;
        bus.req = 2'b00;
        exp_q.push_back('{16'h5555, 1'b0, 1});
        exp_q.push_back('{16'h0000, 1'b1, 1});
        exp_q.push_back('{16'h0000, 1'b1, 1});
        for (int b = 0; b < 3; b++) begin
            wait_cycles(14);
            pulse_ready();
            f = exp_q.pop_front();
            tests_run++;
            if (bus.LoadData !== f.data || bus.underrun !== f.urun || bus.active_src !== 1'(f.src)) begin
                tests_failed++;
                $display("FAIL underrun_load%0d: got data=%h urun=%b src=%0d expected data=%h urun=%b src=%0d",
                         b, bus.LoadData, bus.underrun, bus.active_src, f.data, f.urun, f.src);
            end
            step();
            tests_run++;
            if (bus.underrun !== 1'b0) begin
                tests_failed++;
                $display("FAIL underrun_width%0d: got %b expected 0", b, bus.underrun);
            end
        end
`ifdef I2S_TX_SCHEDULER_UNDERRUN_CNT_EN
        tests_run++;
        if (bus.underrun_count !== 16'd2) begin
            tests_failed++;
            $display("FAIL underrun_count: got %0d expected 2", bus.underrun_count);
        end
`endif
    endtask

    task automatic test_coincident();
        frame_t f;
        wait_cycles(5);
        bus.req_data[15:0] = 16'hC3C3;
        bus.req            = 2'b01;
        exp_q.push_back('{16'h0000, 1'b1, 1});
        exp_q.push_back('{16'hC3C3, 1'b0, 0});
        pulse_ready();
        tests_run++;
        if (bus.gnt !== 2'b01) begin
            tests_failed++;
            $display("FAIL coinc_gnt: got %b expected 01", bus.gnt);
        end
        f = exp_q.pop_front();
        tests_run++;
        if (bus.LoadData !== f.data || bus.underrun !== f.urun || bus.active_src !== 1'(f.src)) begin
            tests_failed++;
            $display("FAIL coinc_silence: got data=%h urun=%b src=%0d expected data=%h urun=%b src=%0d",
                     bus.LoadData, bus.underrun, bus.active_src, f.data, f.urun, f.src);
        end
        bus.req = 2'b00;
        wait_cycles(15);
        pulse_ready();
        f = exp_q.pop_front();
        tests_run++;
        if (bus.LoadData !== f.data || bus.underrun !== f.urun || bus.active_src !== 1'(f.src)) begin
            tests_failed++;
            $display("FAIL coinc_load: got data=%h urun=%b src=%0d expected data=%h urun=%b src=%0d",
                     bus.LoadData, bus.underrun, bus.active_src, f.data, f.urun, f.src);
        end
`ifdef I2S_TX_SCHEDULER_UNDERRUN_CNT_EN
        tests_run++;
        if (bus.underrun_count !== 16'd3) begin
            tests_failed++;
            $display("FAIL coinc_count: got %0d expected 3", bus.underrun_count);
        end
`endif
    endtask

    task automatic test_enable_drop();
        frame_t f;
        bus.req_data[15:0] = 16'h1234;
        bus.req            = 2'b01;
        exp_q.push_back('{16'h0000, 1'b0, 0});
        exp_q.push_back('{16'h0000, 1'b1, 0});
        step();
        tests_run++;
        if (bus.gnt !== 2'b01) begin
            tests_failed++;
            $display("FAIL endrop_gnt: got %b expected 01", bus.gnt);
        end
        bus.req = 2'b00;
        enable  = 1'b0;
        step();
        enable = 1'b1;
        pulse_ready();
        f = exp_q.pop_front();
        tests_run++;
        if (bus.LoadData !== f.data || bus.underrun !== f.urun || bus.active_src !== 1'(f.src)) begin
            tests_failed++;
            $display("FAIL endrop_mute: got data=%h urun=%b src=%0d expected data=%h urun=%b src=%0d",
                     bus.LoadData, bus.underrun, bus.active_src, f.data, f.urun, f.src);
        end
        wait_cycles(15);
        pulse_ready();
        f = exp_q.pop_front();
        tests_run++;
        if (bus.LoadData !== f.data || bus.underrun !== f.urun || bus.active_src !== 1'(f.src)) begin
            tests_failed++;
            $display("FAIL endrop_lost: got data=%h urun=%b src=%0d expected data=%h urun=%b src=%0d",
                     bus.LoadData, bus.underrun, bus.active_src, f.data, f.urun, f.src);
        end
`ifdef I2S_TX_SCHEDULER_UNDERRUN_CNT_EN
        tests_run++;
        if (bus.underrun_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL endrop_count: got %0d expected 1", bus.underrun_count);
        end
`endif
    endtask

    task automatic test_reset_in_gnt();
        frame_t f;
        bus.req_data[31:16] = 16'h7E7E;
        bus.req             = 2'b10;
        exp_q.push_back('{16'h7E7E, 1'b0, 1});
        step();
        tests_run++;
        if (bus.gnt !== 2'b10) begin
            tests_failed++;
            $display("FAIL rstg_gnt1: got %b expected 10", bus.gnt);
        end
        bus.req = 2'b00;
        wait_cycles(10);
        pulse_ready();
        f = exp_q.pop_front();
        tests_run++;
        if (bus.LoadData !== f.data || bus.underrun !== f.urun || bus.active_src !== 1'(f.src)) begin
            tests_failed++;
            $display("FAIL rstg_load: got data=%h urun=%b src=%0d expected data=%h urun=%b src=%0d",
                     bus.LoadData, bus.underrun, bus.active_src, f.data, f.urun, f.src);
        end
        bus.req_data[15:0] = 16'h1111;
        bus.req            = 2'b11;
        step();
        tests_run++;
        if (bus.gnt !== 2'b01) begin
            tests_failed++;
            $display("FAIL rstg_gnt0: got %b expected 01", bus.gnt);
        end
        nreset = 1'b1;
        step();
        tests_run++;
        if (bus.gnt !== 2'b00 || bus.LoadData !== 16'h0000 || bus.active_src !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstg_clear: got gnt=%b data=%h src=%0d expected gnt=00 data=0000 src=0",
                     bus.gnt, bus.LoadData, bus.active_src);
        end
        nreset = 1'b0;
        step();
        step();
        tests_run++;
        if (bus.gnt !== 2'b01) begin
            tests_failed++;
            $display("FAIL rstg_first_gnt: got %b expected 01", bus.gnt);
        end
        bus.req = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_underrun();
        test_coincident();
        test_enable_drop();
        test_reset_in_gnt();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
